// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the EHXPLLL dynamic phase-step controller.
package pll_phase_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        PULSE  = 2'b10,
        SETTLE = 2'b11
    } state_t;

    localparam logic [1:0] SEL_CLKOS  = 2'b00;
    localparam logic [1:0] SEL_CLKOS2 = 2'b01;
    localparam logic [1:0] SEL_CLKOS3 = 2'b10;
    localparam logic [1:0] SEL_CLKOP  = 2'b11;

    localparam int DEF_SETUP_CYCLES  = 4;
    localparam int DEF_PULSE_CYCLES  = 4;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_STEP_W        = 8;
    localparam int DEF_PHASE_MOD     = 120;
    localparam int DEF_POS_W         = 7;

endpackage

// File: rtl/pll_phase_stepper_if.sv
// Valid/ready command channel into the phase stepper.
interface pll_phase_stepper_if
    import pll_phase_pkg::*;
#(
    parameter int STEP_W = DEF_STEP_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_sel;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_sel,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_sel,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );

endinterface

// File: rtl/pll_phase_stepper_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync_2ff
    import pll_phase_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_phase_stepper.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP on an ECP5 EHXPLLL from a command
// channel, tracking the fine-phase position of each of the four outputs.
module pll_phase_stepper
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int STEP_W        = DEF_STEP_W,
    parameter int PHASE_MOD     = DEF_PHASE_MOD,
    parameter int POS_W         = DEF_POS_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pll_locked,
    pll_phase_stepper_if.slave   cmd,
    output logic                 busy,
    output logic                 done,
    output logic                 abort,
    output logic                 locked,
    output logic [4*POS_W-1:0]   phase_pos,
    output logic [1:0]           pll_phasesel,
    output logic                 pll_phasedir,
    output logic                 pll_phasestep
);

    localparam int CNT_MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(PHASE_MOD - 1);

    state_t                  state_r,  state_s;
    logic [CNT_W-1:0]        cnt_r,    cnt_s;
    logic [STEP_W-1:0]       remain_r, remain_s;
    logic [1:0]              sel_r,    sel_s;
    logic                    dir_r,    dir_s;
    logic                    step_r,   step_s;
    logic                    done_r,   done_s;
    logic                    abort_r,  abort_s;
    logic                    busy_r;
    logic [3:0][POS_W-1:0]   pos_r,    pos_s;
    logic [POS_W-1:0]        cur_pos_s;
    logic [POS_W-1:0]        nxt_pos_s;
    logic                    locked_s;
    logic                    accept_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign cmd.cmd_ready = (state_r == IDLE) && locked_s;
    assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;

    // Next position of the selected output after one step, wrapping modulo PHASE_MOD.
    always_comb begin
        cur_pos_s = pos_r[sel_r];
        nxt_pos_s = cur_pos_s;
        if (dir_r) begin
            if (cur_pos_s == POS_LAST) begin
                nxt_pos_s = {POS_W{1'b0}};
            end else begin
                nxt_pos_s = cur_pos_s + POS_W'(1);
            end
        end else begin
            if (cur_pos_s == {POS_W{1'b0}}) begin
                nxt_pos_s = POS_LAST;
            end else begin
                nxt_pos_s = cur_pos_s - POS_W'(1);
            end
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        remain_s = remain_r;
        sel_s    = sel_r;
        dir_s    = dir_r;
        step_s   = 1'b1;
        done_s   = 1'b0;
        abort_s  = 1'b0;
        pos_s    = pos_r;

        case (state_r)
            IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (accept_s) begin
                    if (cmd.cmd_steps == {STEP_W{1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        state_s  = SETUP;
                        sel_s    = cmd.cmd_sel;
                        dir_s    = cmd.cmd_dir;
                        remain_s = cmd.cmd_steps;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            SETUP: begin
                if (!locked_s) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    done_s  = 1'b1;
                    abort_s = 1'b1;
                end else if (cnt_r == SETUP_LAST) begin
                    state_s = PULSE;
                    cnt_s   = {CNT_W{1'b0}};
                    step_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            // A pulse already started always runs its full width and is counted.
            PULSE: begin
                if (cnt_r == PULSE_LAST) begin
                    cnt_s    = {CNT_W{1'b0}};
                    remain_s = remain_r - STEP_W'(1);
                    for (int k = 0; k < 4; k++) begin
                        if (sel_r == 2'(k)) begin
                            pos_s[k] = nxt_pos_s;
                        end else begin
                            pos_s[k] = pos_r[k];
                        end
                    end
                    if (!locked_s) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                        abort_s = 1'b1;
                    end else begin
                        state_s = SETTLE;
                    end
                end else begin
                    step_s = 1'b0;
                    cnt_s  = cnt_r + CNT_W'(1);
                end
            end

            SETTLE: begin
                if (!locked_s) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    done_s  = 1'b1;
                    abort_s = 1'b1;
                end else if (cnt_r == SETTLE_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (remain_r != {STEP_W{1'b0}}) begin
                        state_s = PULSE;
                        step_s  = 1'b0;
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset returns the PLL pins to their static idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            remain_r <= {STEP_W{1'b0}};
            sel_r    <= SEL_CLKOS;
            dir_r    <= 1'b1;
            step_r   <= 1'b1;
            done_r   <= 1'b0;
            abort_r  <= 1'b0;
            busy_r   <= 1'b0;
            pos_r    <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            remain_r <= remain_s;
            sel_r    <= sel_s;
            dir_r    <= dir_s;
            step_r   <= step_s;
            done_r   <= done_s;
            abort_r  <= abort_s;
            busy_r   <= (state_s != IDLE);
            pos_r    <= pos_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign abort         = abort_r;
    assign locked        = locked_s;
    assign phase_pos     = pos_r;
    assign pll_phasesel  = sel_r;
    assign pll_phasedir  = dir_r;
    assign pll_phasestep = step_r;

endmodule
